// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control front-end.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_PAUSE = 3'b010,
        ST_CLEAR = 3'b011
    } state_t;

    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_PAUSE = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;
    localparam logic [2:0] CMD_LAP   = 3'b100;

    // Bits needed to hold 0..PERIOD-1 where PERIOD = clk_hz / tick_hz.
    function automatic int unsigned presc_width(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
        int unsigned period;
        int unsigned w;
        period = clk_hz / tick_hz;
        w = 1;
        while ((64'(1) << w) < 64'(period)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw switch.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // A sample equal to the accepted value restarts the run of differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control: switch conditioning, RUN/PAUSE/CLEAR FSM, count-enable prescaler, lap and led.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch0,
    input  logic       switch1,
    input  logic       switch2,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic [2:0] state,
    output logic       led
);

    localparam int unsigned   PERIOD = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW     = presc_width(CLK_HZ, TICK_HZ);
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] P_HALF = PW'(PERIOD / 2);

    logic          db0;
    logic          db1;
    logic          db2;
    logic [2:0]    cmd;
    logic          lap_prev;
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          cnt_en_d;
    logic          cnt_clr_d;
    logic          lap_d;
    logic          led_d;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk (clk), .rst (rst), .raw (switch0), .db (db0)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk (clk), .rst (rst), .raw (switch1), .db (db1)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk (clk), .rst (rst), .raw (switch2), .db (db2)
    );

    assign cmd   = {db2, db1, db0};
    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = '0;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        lap_d     = lap_hold;
        led_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd == CMD_START) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cmd == CMD_PAUSE)      state_d = ST_PAUSE;
                else if (cmd == CMD_CLEAR) state_d = ST_CLEAR;
            end
            ST_PAUSE: begin
                if (cmd == CMD_START)      state_d = ST_RUN;
                else if (cmd == CMD_CLEAR) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cmd == CMD_START) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap only emits a pulse if the FSM stays in RUN across that edge.
        if (state_q == ST_RUN) begin
            presc_d  = (presc_q == P_LAST) ? '0 : presc_q + PW'(1);
            cnt_en_d = (presc_q == P_LAST) && (state_d == ST_RUN);
        end else if (state_q == ST_PAUSE) begin
            presc_d = presc_q;
        end
        if ((state_d == ST_IDLE) || (state_d == ST_CLEAR)) begin
            presc_d = '0;
        end

        // Lap toggles on the LAP edge only; holding LAP is ignored.
        if ((state_d == ST_IDLE) || (state_d == ST_CLEAR)) begin
            lap_d = 1'b0;
        end else if (((state_q == ST_RUN) || (state_q == ST_PAUSE)) &&
                     (cmd == CMD_LAP) && !lap_prev) begin
            lap_d = ~lap_hold;
        end

        cnt_clr_d = (state_d == ST_CLEAR);
        led_d     = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) && (presc_d >= P_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            lap_prev <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_hold <= 1'b0;
            led      <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            lap_prev <= (cmd == CMD_LAP);
            cnt_en   <= cnt_en_d;
            cnt_clr  <= cnt_clr_d;
            lap_hold <= lap_d;
            led      <= led_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with PERIOD=20 and a 4-sample debounce.
module tb_stopwatch_sequencer;

    localparam int unsigned CLK_HZ  = 20;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned DEB     = 4;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_hold;
    logic [2:0] state;
    logic       led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sw;
        logic [2:0] st;
        logic       clr;
        logic       lap;
    } vec_t;

    vec_t vecs[16];

    stopwatch_sequencer #(
        .CLK_HZ          (CLK_HZ),
        .TICK_HZ         (TICK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .switch0  (sw[0]),
        .switch1  (sw[1]),
        .switch2  (sw[2]),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .lap_hold (lap_hold),
        .state    (state),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_cnt_en"}, int'(cnt_en), 0);
        check({tag, "_cnt_clr"}, int'(cnt_clr), 0);
        check({tag, "_lap_hold"}, int'(lap_hold), 0);
        check({tag, "_led"}, int'(led), 0);
    endtask

    task automatic wait_state(input logic [2:0] target, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((state != target) && (n < bound));
    endtask

    task automatic wait_pulse(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cnt_en && (n < bound));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw  = 3'b000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] prev;

        vecs[0]  = '{3'b010, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{3'b011, 3'b000, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 3'b001, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 3'b001, 1'b0, 1'b1};
        vecs[4]  = '{3'b010, 3'b010, 1'b0, 1'b1};
        vecs[5]  = '{3'b100, 3'b010, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 3'b001, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 3'b011, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 3'b011, 1'b1, 1'b0};
        vecs[9]  = '{3'b000, 3'b011, 1'b1, 1'b0};
        vecs[10] = '{3'b001, 3'b001, 1'b0, 1'b0};
        vecs[11] = '{3'b011, 3'b011, 1'b1, 1'b0};
        vecs[12] = '{3'b001, 3'b001, 1'b0, 1'b0};
        vecs[13] = '{3'b110, 3'b001, 1'b0, 1'b0};
        vecs[14] = '{3'b111, 3'b001, 1'b0, 1'b0};
        vecs[15] = '{3'b100, 3'b001, 1'b0, 1'b1};

        // Reset with random switches
        rst = 1'b1;
        sw  = 3'($urandom);
        step();
        check_all_zero("reset_first_edge");
        step();
        check("reset_second_state", int'(state), 0);
        rst = 1'b0;
        sw  = 3'b000;
        step(2);

        // START latency, then pulse and led cadence over three periods
        sw = 3'b001;
        wait_state(3'b001, 20, n);
        check("start_latency", n, 7);
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("run_cnt_en_k%0d", k), int'(cnt_en), int'(k % 20 == 0));
            check($sformatf("run_led_k%0d", k), int'(led), int'((k % 20) >= 10));
        end

        // Command table: state unchanged 6 edges after the switch change, updated on the 7th
        do_reset();
        prev = 3'b000;
        for (int i = 0; i < 16; i++) begin
            sw = vecs[i].sw;
            step(6);
            check($sformatf("vec%0d_hold_state", i), int'(state), int'(prev));
            step();
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            check($sformatf("vec%0d_cnt_clr", i), int'(cnt_clr), int'(vecs[i].clr));
            check($sformatf("vec%0d_lap_hold", i), int'(lap_hold), int'(vecs[i].lap));
            prev = vecs[i].st;
        end

        // Three-cycle glitch rejected, four-cycle level accepted
        do_reset();
        sw = 3'b001;
        step(3);
        sw = 3'b000;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("glitch_state", int'(state), 0);
            check("glitch_cnt_en", int'(cnt_en), 0);
        end
        sw = 3'b001;
        step(4);
        sw = 3'b000;
        step(3);
        check("stable4_accepted", int'(state), 1);

        // Pause with prescaler at 7, resume, remaining 13 cycles to the pulse
        do_reset();
        sw = 3'b001;
        wait_state(3'b001, 20, n);
        check("t4_start_latency", n, 7);
        sw = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t4_pre_pause_cnt_en", int'(cnt_en), 0);
        end
        check("t4_pause_state", int'(state), 2);
        for (int k = 1; k <= 25; k++) begin
            step();
            check("t4_pause_cnt_en", int'(cnt_en), 0);
            check("t4_pause_led", int'(led), 0);
            check("t4_pause_state_hold", int'(state), 2);
        end
        sw = 3'b001;
        wait_state(3'b001, 20, n);
        check("t4_resume_latency", n, 7);
        wait_pulse(40, n);
        check("t4_resume_to_pulse", n, 13);

        // Lap set, then CLEAR forces outputs low; restart gives a full period
        sw = 3'b100;
        step(7);
        check("t5_lap_set", int'(lap_hold), 1);
        sw = 3'b011;
        step(7);
        check("t5_clear_state", int'(state), 3);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            check("t5_clear_cnt_clr", int'(cnt_clr), 1);
            check("t5_clear_lap", int'(lap_hold), 0);
            check("t5_clear_led", int'(led), 0);
            check("t5_clear_cnt_en", int'(cnt_en), 0);
        end
        sw = 3'b001;
        wait_state(3'b001, 20, n);
        check("t5_start_latency", n, 7);
        check("t5_run_cnt_clr", int'(cnt_clr), 0);
        wait_pulse(40, n);
        check("t5_first_pulse", n, 20);

        // Held LAP toggles once; a second LAP edge toggles back
        sw = 3'b100;
        step(7);
        check("t6_lap_on", int'(lap_hold), 1);
        for (int k = 1; k <= 23; k++) begin
            step();
            check("t6_lap_held", int'(lap_hold), 1);
        end
        sw = 3'b001;
        step(10);
        check("t6_lap_after_release", int'(lap_hold), 1);
        sw = 3'b100;
        step(7);
        check("t6_lap_off", int'(lap_hold), 0);
        check("t6_state_run", int'(state), 1);
        step(5);
        rst = 1'b1;
        sw  = 3'b000;
        step();
        check_all_zero("t6_mid_reset");
        rst = 1'b0;

        // PAUSE decoded on the wrap edge suppresses that pulse
        sw = 3'b001;
        wait_state(3'b001, 20, n);
        check("t7_start_latency", n, 7);
        step(13);
        sw = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("t7_cnt_en_k%0d", k), int'(cnt_en), 0);
        end
        check("t7_pause_state", int'(state), 2);
        check("t7_pause_led", int'(led), 0);
        step();
        check("t7_after_cnt_en", int'(cnt_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
